// File: rtl/id_fsm.sv
// Identifier recognizer: out is high while the current token is letters followed by digits.
// Optional macro ID_FSM_UNDERSCORE_EN makes '_' count as a letter.
module id_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic       out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ALPHA = 2'b01,
    NUM   = 2'b10
  } state_t;

  // Initializer gives a defined IDLE state in simulation before the first reset.
  state_t state = IDLE;
  state_t nxt;

  logic is_letter;
  logic is_digit;

  always_comb begin
    is_letter = ((char >= 8'h41) && (char <= 8'h5A)) ||
                ((char >= 8'h61) && (char <= 8'h7A));
`ifdef ID_FSM_UNDERSCORE_EN
    is_letter = is_letter || (char == 8'h5F);
`else
    is_letter = is_letter;
`endif
    is_digit  = (char >= 8'h30) && (char <= 8'h39);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: begin
        if (is_letter) nxt = ALPHA;
        else           nxt = IDLE;
      end
      ALPHA, NUM: begin
        if (is_letter)     nxt = ALPHA;
        else if (is_digit) nxt = NUM;
        else               nxt = IDLE;
      end
      // 2'b11 is unreachable; force it back to IDLE whatever the input
      default: nxt = IDLE;
    endcase
  end

  assign out = (state == NUM);

endmodule

// File: tb/tb_id_fsm.sv
// Bench for id_fsm: directed sequences plus random traffic checked against a token-based model.
module tb_id_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char = 8'h20;
  logic       out;

  int compared = 0;
  int mismatched = 0;

  // Model state: characters of the current token (since the last separator or reset).
  byte unsigned tok[$];

  id_fsm dut (
    .clk  (clk),
    .reset(reset),
    .char (char),
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic bit m_letter(byte unsigned c);
    bit r;
    r = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
`ifdef ID_FSM_UNDERSCORE_EN
    if (c == 8'h5F) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic bit m_digit(byte unsigned c);
    return (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Match iff the token ends in a digit run that is immediately preceded by a letter.
  function automatic bit m_out();
    int i;
    int n;
    n = tok.size();
    if (n == 0) return 1'b0;
    if (!m_digit(tok[n-1])) return 1'b0;
    i = n - 1;
    while (i >= 0 && m_digit(tok[i])) i--;
    if (i < 0) return 1'b0;
    return m_letter(tok[i]);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: out=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive, update model, sample 1ns after the edge and compare.
  task automatic cyc(input logic [7:0] c, input logic r, input string tag);
    char  = c;
    reset = r;
    @(posedge clk);
    if (r) tok.delete();
    else if (m_letter(c) || m_digit(c)) tok.push_back(c);
    else tok.delete();
    #1;
    check(tag, out, m_out());
    reset = 1'b0;
  endtask

  task automatic seq_lit(input string s, input logic [15:0] exp, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      cyc(s[i], 1'b0, tag);
      check({tag, "_lit"}, out, exp[i]);
    end
  endtask

  initial begin
    string bnd;
    logic [7:0] c;

    #1;
    check("init_idle", out, 1'b0);

    // Letters/digits/separators with no reset applied yet
    seq_lit("ab32)1e1e6", 16'b10_1000_1100, "seq_basic");

    // Reset in NUM discards the run; a digit afterwards stays idle
    cyc("x", 1'b0, "rst_pre_x");
    cyc("9", 1'b0, "rst_pre_9");
    check("rst_pre_lit", out, 1'b1);
    cyc("q", 1'b1, "rst_edge");
    check("rst_edge_lit", out, 1'b0);
    cyc("5", 1'b0, "rst_post5");
    check("rst_post5_lit", out, 1'b0);

    // Characters just outside the letter/digit ranges act as separators
    bnd = "@[`{/:";
    for (int i = 0; i < bnd.len(); i++) begin
      cyc("a", 1'b0, "bnd_a");
      cyc(bnd[i], 1'b0, "bnd_sep");
      cyc("1", 1'b0, "bnd_1");
      check("bnd_lit", out, 1'b0);
    end

    seq_lit("Z0z9", 16'b1010, "edges");
    cyc(" ", 1'b0, "sep");
    seq_lit("1a", 16'b00, "lead_digit");

    cyc(" ", 1'b0, "sep");
`ifdef ID_FSM_UNDERSCORE_EN
    seq_lit("_a1", 16'b100, "us_a1");
    cyc(" ", 1'b0, "sep");
    seq_lit("_1", 16'b10, "us_1");
`else
    seq_lit("_1", 16'b00, "us_1");
`endif

    // Long run: unbounded letters then digits
    cyc(" ", 1'b0, "sep");
    for (int i = 0; i < 300; i++) begin
      cyc(8'(8'h61 + (i % 26)), 1'b0, "long_let");
      check("long_let_lit", out, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      cyc(8'(8'h30 + (i % 10)), 1'b0, "long_dig");
      check("long_dig_lit", out, 1'b1);
    end

    // Random traffic biased toward letters and digits, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: c = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h41, 8'h5A))
                                                  : 8'($urandom_range(8'h61, 8'h7A));
        3, 4, 5, 6: c = 8'($urandom_range(8'h30, 8'h39));
        7: c = 8'h5F;
        default: c = 8'($urandom_range(0, 255));
      endcase
      cyc(c, ($urandom_range(0, 49) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
